// File: rtl/ysyx_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit and its bus interface.
package ysyx_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ysyx_fetch_unit_if.sv
// Instruction memory request/response bus.
// The fetch unit is master; instruction memory is slave.
interface ysyx_fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/ysyx_fetch_unit.sv
// Instruction fetch stage: owns the PC, one fetch in flight,
// one-entry output register toward decode, redirect handling.
module ysyx_fetch_unit #(
    parameter int                        XLEN     = ysyx_pkg::XLEN,
    parameter logic [ysyx_pkg::XLEN-1:0] RESET_PC = ysyx_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_fetch_unit_if.master      imem,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_inst,
    output logic [XLEN-1:0]        out_pc
);

    import ysyx_pkg::*;

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            kill, kill_n;
    logic [XLEN-1:0] inst_q, inst_n;
    logic [XLEN-1:0] opc_q, opc_n;
    logic [XLEN-1:0] redir;
    logic            unused_bits;

    assign redir       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            kill   <= 1'b0;
            inst_q <= NOP;
            opc_q  <= RESET_PC;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            kill   <= kill_n;
            inst_q <= inst_n;
            opc_q  <= opc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        inst_n  = inst_q;
        opc_n   = opc_q;
        unique case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (redirect_valid) pc_n = redir;
                if (imem.req_ready) begin
                    state_n = WAIT;
                    kill_n  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    // Stale or superseded fetch: drop it and refetch.
                    if (kill || redirect_valid) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                        if (redirect_valid) pc_n = redir;
                    end else begin
                        inst_n  = imem.rsp_data;
                        opc_n   = pc;
                        state_n = HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_n = 1'b1;
                    pc_n   = redir;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redir;
                    state_n = REQ;
                end else if (out_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign imem.req_valid = (state == REQ);
    assign imem.req_addr  = pc;
    assign out_valid      = (state == HOLD);
    assign out_inst       = inst_q;
    assign out_pc         = opc_q;

endmodule
